// File: rtl/magic_pkg.sv
// Shared types for the MAGIC NOR executor: opcodes, FSM states and the latched instruction.
package magic_pkg;

    localparam int CELL_ADDR_W = 6;

    typedef enum logic [1:0] {
        OP_NOR2 = 2'd0,
        OP_INV1 = 2'd1,
        OP_OUT  = 2'd2,
        OP_END  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_INIT  = 2'd2,
        S_EVAL  = 2'd3
    } state_e;

    typedef struct packed {
        op_e                    op;
        logic [CELL_ADDR_W-1:0] a;
        logic [CELL_ADDR_W-1:0] b;
        logic [CELL_ADDR_W-1:0] d;
    } instr_t;

endpackage

// File: rtl/magic_cell_row.sv
// One crossbar row of bit cells: two combinational read ports, one write port,
// and a bulk load that places the primary inputs in the low cells and clears the rest.
module magic_cell_row #(
    parameter int NUM_CELLS = 64,
    parameter int ADDR_W    = 6,
    parameter int NUM_IN    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [NUM_IN-1:0] load_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic              rdata_a,
    output logic              rdata_b
);

    logic cells_reg [NUM_CELLS];

    generate
        for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            // Load takes priority over a gate write; the FSM never asserts both.
            if (gi < NUM_IN) begin : g_pi
                always_ff @(posedge clk) begin
                    if (rst)
                        cells_reg[gi] <= 1'b0;
                    else if (load)
                        cells_reg[gi] <= load_data[gi];
                    else if (we && waddr == ADDR_W'(gi))
                        cells_reg[gi] <= wdata;
                end
            end else begin : g_work
                always_ff @(posedge clk) begin
                    if (rst || load)
                        cells_reg[gi] <= 1'b0;
                    else if (we && waddr == ADDR_W'(gi))
                        cells_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata_a = cells_reg[raddr_a];
    assign rdata_b = cells_reg[raddr_b];

endmodule

// File: rtl/magic_nor_executor.sv
// Sequential MAGIC NOR2/INV1 evaluator: fetches gate instructions and runs each
// as an INIT step (output cell to 1) followed by an EVAL step (output cell to NOR).
module magic_nor_executor
    import magic_pkg::*;
#(
    parameter int NUM_CELLS = 64,
    parameter int ADDR_W    = CELL_ADDR_W,
    parameter int NUM_IN    = 10,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_IN-1:0] x,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_a,
    input  logic [ADDR_W-1:0] instr_b,
    input  logic [ADDR_W-1:0] instr_d,
    output logic              z,
    output logic              z_valid,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  gate_count,
    output logic [CNT_W-1:0]  step_count
);

    localparam logic [ADDR_W:0] NUM_IN_L = (ADDR_W + 1)'(NUM_IN);

    state_e            state_reg, state_next;
    instr_t            instr_reg, instr_next;
    logic              err_reg, err_next;
    logic              z_reg, z_next;
    logic              z_valid_reg, z_valid_next;
    logic              done_reg, done_next;
    logic [CNT_W-1:0]  gate_reg, gate_next;
    logic [CNT_W-1:0]  step_reg, step_next;

    logic              row_load, row_we, row_wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic              rdata_a, rdata_b;
    logic              ready_int;
    logic              hazard, pi_overwrite;
    op_e               op_in;

    assign op_in        = op_e'(instr_op);
    assign hazard       = (instr_d == instr_a) || (op_in == OP_NOR2 && instr_d == instr_b);
    assign pi_overwrite = {1'b0, instr_d} < NUM_IN_L;
    // Port A serves OUT reads while fetching and gate operand A during EVAL.
    assign raddr_a      = (state_reg == S_FETCH) ? instr_a : instr_reg.a;

    magic_cell_row #(
        .NUM_CELLS (NUM_CELLS),
        .ADDR_W    (ADDR_W),
        .NUM_IN    (NUM_IN)
    ) u_row (
        .clk       (clk),
        .rst       (rst),
        .load      (row_load),
        .load_data (x),
        .we        (row_we),
        .waddr     (instr_reg.d),
        .wdata     (row_wdata),
        .raddr_a   (raddr_a),
        .raddr_b   (instr_reg.b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            instr_reg   <= '0;
            err_reg     <= 1'b0;
            z_reg       <= 1'b0;
            z_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
            gate_reg    <= '0;
            step_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            instr_reg   <= instr_next;
            err_reg     <= err_next;
            z_reg       <= z_next;
            z_valid_reg <= z_valid_next;
            done_reg    <= done_next;
            gate_reg    <= gate_next;
            step_reg    <= step_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        instr_next   = instr_reg;
        err_next     = err_reg;
        z_next       = z_reg;
        z_valid_next = 1'b0;
        done_next    = 1'b0;
        gate_next    = gate_reg;
        step_next    = step_reg;
        row_load     = 1'b0;
        row_we       = 1'b0;
        row_wdata    = 1'b0;
        ready_int    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    row_load   = 1'b1;
                    err_next   = 1'b0;
                    gate_next  = '0;
                    step_next  = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                ready_int = 1'b1;
                if (instr_valid) begin
                    case (op_in)
                        OP_NOR2, OP_INV1: begin
                            // A self-referencing gate is dropped so the fetch slot frees up next cycle.
                            if (hazard) begin
                                err_next = 1'b1;
                            end else begin
                                instr_next = '{op: op_in, a: instr_a, b: instr_b, d: instr_d};
                                if (pi_overwrite)
                                    err_next = 1'b1;
                                state_next = S_INIT;
                            end
                        end
                        OP_OUT: begin
                            z_next       = rdata_a;
                            z_valid_next = 1'b1;
                        end
                        default: begin
                            done_next  = 1'b1;
                            state_next = S_IDLE;
                        end
                    endcase
                end
            end
            S_INIT: begin
                row_we    = 1'b1;
                row_wdata = 1'b1;
                if (step_reg != '1)
                    step_next = step_reg + CNT_W'(1);
                state_next = S_EVAL;
            end
            S_EVAL: begin
                row_we    = 1'b1;
                row_wdata = (instr_reg.op == OP_INV1) ? ~rdata_a : ~(rdata_a | rdata_b);
                if (step_reg != '1)
                    step_next = step_reg + CNT_W'(1);
                if (gate_reg != '1)
                    gate_next = gate_reg + CNT_W'(1);
                state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are forced to their reset values for the whole time rst is high.
    assign instr_ready = ready_int & ~rst;
    assign busy        = (state_reg != S_IDLE) & ~rst;
    assign z           = z_reg & ~rst;
    assign z_valid     = z_valid_reg & ~rst;
    assign done        = done_reg & ~rst;
    assign err         = err_reg & ~rst;
    assign gate_count  = rst ? '0 : gate_reg;
    assign step_count  = rst ? '0 : step_reg;

endmodule

// File: tb/tb_magic_nor_executor.sv
// Directed-vector bench for magic_nor_executor; a second, narrow-counter instance
// shares the stimulus so counter saturation is reached in a short run.
module tb_magic_nor_executor;

    localparam int NUM_CELLS = 64;
    localparam int ADDR_W    = 6;
    localparam int NUM_IN    = 10;
    localparam int CNT_W     = 16;
    localparam int SAT_W     = 4;

    localparam logic [1:0] NOR2 = 2'd0;
    localparam logic [1:0] INV1 = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;
    localparam logic [1:0] ENDI = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NUM_IN-1:0] x = '0;
    logic              instr_valid = 1'b0;
    logic [1:0]        instr_op = '0;
    logic [ADDR_W-1:0] instr_a = '0, instr_b = '0, instr_d = '0;
    logic              instr_ready, z, z_valid, done, busy, err;
    logic [CNT_W-1:0]  gate_count, step_count;
    logic              s_instr_ready, s_z, s_z_valid, s_done, s_busy, s_err;
    logic [SAT_W-1:0]  s_gate_count, s_step_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    magic_nor_executor #(
        .NUM_CELLS(NUM_CELLS), .ADDR_W(ADDR_W), .NUM_IN(NUM_IN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_a(instr_a), .instr_b(instr_b), .instr_d(instr_d),
        .z(z), .z_valid(z_valid), .done(done), .busy(busy), .err(err),
        .gate_count(gate_count), .step_count(step_count)
    );

    magic_nor_executor #(
        .NUM_CELLS(NUM_CELLS), .ADDR_W(ADDR_W), .NUM_IN(NUM_IN), .CNT_W(SAT_W)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .instr_valid(instr_valid), .instr_ready(s_instr_ready), .instr_op(instr_op),
        .instr_a(instr_a), .instr_b(instr_b), .instr_d(instr_d),
        .z(s_z), .z_valid(s_z_valid), .done(s_done), .busy(s_busy), .err(s_err),
        .gate_count(s_gate_count), .step_count(s_step_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction, waits (bounded) for ready and returns after the accept edge.
    task automatic issue(input logic [1:0] op, input int a, input int b, input int d,
                         output int waited);
        waited = 0;
        instr_valid = 1'b1;
        instr_op = op;
        instr_a = ADDR_W'(a);
        instr_b = ADDR_W'(b);
        instr_d = ADDR_W'(d);
        while (!instr_ready && waited < 20) begin
            cyc();
            waited++;
        end
        check("ready_wait", 32'(waited < 20), 32'd1);
        cyc();
        instr_valid = 1'b0;
        $display("instr op=%0d a=%0d b=%0d d=%0d waited=%0d", op, a, b, d, waited);
    endtask

    // Gate with standard latency: INIT and EVAL cycles not ready, then ready again.
    task automatic gate(input logic [1:0] op, input int a, input int b, input int d);
        int w;
        issue(op, a, b, d, w);
        check("init_ready", 32'(instr_ready), 32'd0);
        cyc();
        check("eval_ready", 32'(instr_ready), 32'd0);
        cyc();
        check("fetch_ready", 32'(instr_ready), 32'd1);
    endtask

    task automatic out_chk(input int a, input logic exp, output int waited);
        issue(OUT, a, 0, 0, waited);
        check("z_valid", 32'(z_valid), 32'd1);
        check("z", 32'(z), 32'(exp));
    endtask

    task automatic end_prog();
        int w;
        issue(ENDI, 0, 0, 0, w);
        check("done", 32'(done), 32'd1);
        check("done_no_zv", 32'(z_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        cyc();
        check("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic do_start(input logic [NUM_IN-1:0] xv);
        x = xv;
        start = 1'b1;
        cyc();
        start = 1'b0;
        $display("start x=%b", xv);
        check("start_busy", 32'(busy), 32'd1);
        check("start_err", 32'(err), 32'd0);
        check("start_gates", 32'(gate_count), 32'd0);
        check("start_steps", 32'(step_count), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(instr_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_z"}, 32'(z), 32'd0);
        check({tag, "_zv"}, 32'(z_valid), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_gates"}, 32'(gate_count), 32'd0);
        check({tag, "_steps"}, 32'(step_count), 32'd0);
    endtask

    initial begin
        int w;
        cyc();
        cyc();
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc();

        // Instructions in IDLE are ignored.
        instr_valid = 1'b1;
        instr_op = OUT;
        cyc();
        check("idle_no_accept", 32'(instr_ready), 32'd0);
        check("idle_no_zv", 32'(z_valid), 32'd0);
        instr_valid = 1'b0;

        // Program 1: NOR2(0,1->20) with x[1:0]=11.
        do_start(10'b0000000011);
        gate(NOR2, 0, 1, 20);
        out_chk(20, 1'b0, w);
        out_chk(0, 1'b1, w);
        check("p1_err", 32'(err), 32'd0);
        end_prog();
        check("p1_gates", 32'(gate_count), 32'd1);
        check("p1_steps", 32'(step_count), 32'd2);

        // Program 2: INV1 chain and NOR2 with x=0, back-to-back OUTs.
        do_start(10'b0);
        gate(INV1, 0, 0, 20);
        gate(INV1, 20, 0, 21);
        gate(NOR2, 21, 20, 22);
        out_chk(22, 1'b0, w);
        out_chk(21, 1'b0, w);
        check("p2_b2b_out", 32'(w), 32'd0);
        out_chk(20, 1'b1, w);
        check("p2_b2b_out2", 32'(w), 32'd0);
        end_prog();
        check("p2_gates", 32'(gate_count), 32'd3);
        check("p2_steps", 32'(step_count), 32'd6);

        // Backpressure: 5 idle cycles in FETCH change nothing; start while busy ignored.
        do_start(10'b0000000100);
        gate(INV1, 2, 0, 24);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            cyc();
            start = 1'b0;
            check("bp_ready", 32'(instr_ready), 32'd1);
            check("bp_gates", 32'(gate_count), 32'd1);
            check("bp_steps", 32'(step_count), 32'd2);
        end
        gate(NOR2, 2, 3, 25);
        out_chk(25, 1'b0, w);
        out_chk(2, 1'b1, w);
        gate(NOR2, 3, 24, 26);
        out_chk(26, 1'b1, w);
        check("bp_gates_end", 32'(gate_count), 32'd3);
        end_prog();

        // Hazard: NOR2 with d==b is skipped, err set, next accept one cycle later.
        do_start(10'b0010000000);
        issue(NOR2, 5, 7, 7, w);
        check("hz_err", 32'(err), 32'd1);
        check("hz_ready", 32'(instr_ready), 32'd1);
        check("hz_gates", 32'(gate_count), 32'd0);
        check("hz_steps", 32'(step_count), 32'd0);
        out_chk(7, 1'b1, w);
        check("hz_next_accept", 32'(w), 32'd0);
        end_prog();
        check("hz_err_sticky", 32'(err), 32'd1);

        // Primary-input overwrite executes and flags err.
        do_start(10'b0);
        gate(INV1, 12, 0, 3);
        check("pi_err", 32'(err), 32'd1);
        check("pi_gates", 32'(gate_count), 32'd1);
        out_chk(3, 1'b1, w);
        end_prog();

        // Reset during EVAL of a gate writing cell 30.
        do_start(10'b0000000001);
        out_chk(0, 1'b1, w);
        issue(INV1, 0, 0, 30, w);
        cyc();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_hold");
        cyc();
        check_reset_outputs("rst_eval");
        rst = 1'b0;
        do_start(10'b0);
        out_chk(30, 1'b0, w);
        end_prog();

        // Saturation: the 4-bit instance saturates, the 16-bit one keeps counting.
        do_start(10'b0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) gate(INV1, 40, 0, 41);
            else            gate(INV1, 41, 0, 40);
        end
        check("sat_gates16", 32'(gate_count), 32'd20);
        check("sat_steps16", 32'(step_count), 32'd40);
        check("sat_gates4", 32'(s_gate_count), 32'hF);
        check("sat_steps4", 32'(s_step_count), 32'hF);
        out_chk(41, 1'b1, w);
        out_chk(40, 1'b0, w);
        end_prog();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
